// File: rtl/async_fifo_prog.sv
// Dual-clock FIFO: Gray-coded pointer crossing, optional first-word-fall-through read port,
// programmable almost flags, per-domain fill levels and sticky overflow/underflow flags.
`timescale 1ns/1ps

module async_fifo_prog_sync #(
    parameter int W      = 9,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];
endmodule

module async_fifo_prog #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int DEPTH       = 256,
    parameter  int SYNC_STAGES = 2,
    parameter  int FWFT        = 0,
    localparam int ADDR_WIDTH  = $clog2(DEPTH),
    localparam int AW1         = ADDR_WIDTH + 1
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW1-1:0]        wr_afull_thresh,
    input  logic                  wr_ovf_clr,
    output logic                  full,
    output logic                  almost_full,
    output logic [AW1-1:0]        wr_level,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [AW1-1:0]        rd_aempty_thresh,
    input  logic                  rd_unf_clr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [AW1-1:0]        rd_level,
    output logic                  underflow
);
    localparam bit FW = (FWFT != 0);

    function automatic logic [AW1-1:0] bin2gray(input logic [AW1-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW1-1:0] gray2bin(input logic [AW1-1:0] g);
        logic [AW1-1:0] b;
        b[AW1-1] = g[AW1-1];
        for (int i = AW1 - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [AW1-1:0] wr_bin, wr_gray, wr_bin_next, wr_gray_next, wr_level_next;
    logic [AW1-1:0] rq_gray;
    logic           wr_accept, full_next;
    logic [AW1-1:0] rd_gray;

    async_fifo_prog_sync #(.W(AW1), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk   (wr_clk),
        .rst_n (wr_rst_n),
        .d     (rd_gray),
        .q     (rq_gray)
    );

    always_comb begin
        wr_accept     = wr_en & ~full;
        wr_bin_next   = wr_bin + AW1'(wr_accept);
        wr_gray_next  = bin2gray(wr_bin_next);
        full_next     = (wr_gray_next == {~rq_gray[AW1-1:AW1-2], rq_gray[AW1-3:0]});
        wr_level_next = wr_bin_next - gray2bin(rq_gray);
    end

    // The threshold is quasi-static configuration, so it also seeds the flag during reset.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin      <= '0;
            wr_gray     <= '0;
            full        <= 1'b0;
            wr_level    <= '0;
            almost_full <= (wr_afull_thresh == '0);
            overflow    <= 1'b0;
        end else begin
            wr_bin      <= wr_bin_next;
            wr_gray     <= wr_gray_next;
            full        <= full_next;
            wr_level    <= wr_level_next;
            almost_full <= (wr_level_next >= wr_afull_thresh);
            overflow    <= (wr_en & full) | (overflow & ~wr_ovf_clr);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_accept) mem[wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
    end

    // ---------------- read domain ----------------
    logic [AW1-1:0] rd_bin, rd_bin_next, retire_next, rd_level_next;
    logic [AW1-1:0] wq_gray;
    logic           mem_empty, mem_empty_next, mem_rd, pop, empty_next;

    async_fifo_prog_sync #(.W(AW1), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .d     (wr_gray),
        .q     (wq_gray)
    );

    // rd_bin is the memory fetch pointer; the pointer handed to the writer retires a slot
    // only once its word has left the output register, keeping occupancy within DEPTH.
    always_comb begin
        pop            = rd_en & ~empty;
        mem_rd         = FW ? (~mem_empty & (empty | pop)) : pop;
        rd_bin_next    = rd_bin + AW1'(mem_rd);
        mem_empty_next = (bin2gray(rd_bin_next) == wq_gray);
        empty_next     = FW ? ~(mem_rd | (~empty & ~pop)) : mem_empty_next;
        retire_next    = rd_bin_next - AW1'(FW & ~empty_next);
        rd_level_next  = gray2bin(wq_gray) - retire_next;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_bin       <= '0;
            rd_gray      <= '0;
            mem_empty    <= 1'b1;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            underflow    <= 1'b0;
            rd_data      <= '0;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_gray      <= bin2gray(retire_next);
            mem_empty    <= mem_empty_next;
            empty        <= empty_next;
            almost_empty <= (rd_level_next <= rd_aempty_thresh);
            rd_level     <= rd_level_next;
            underflow    <= (rd_en & empty) | (underflow & ~rd_unf_clr);
            if (mem_rd) rd_data <= mem[rd_bin[ADDR_WIDTH-1:0]];
        end
    end
endmodule
